pipeline_hazard_ctrl: RTL
=========================

Name: pipeline_hazard_ctrl

Overview:
Central hazard and sequencing controller for the 5-stage RISC-V pipeline. It drives the stall, flush and clear controls of the F/D, D/E and E/M pipeline registers; the D/E clear is the register's clr input.
It also generates the E-stage operand forwarding selects and sequences the multi-cycle mul/div unit (MDU) with a start/done handshake FSM. It keeps stall and flush performance counters.

Parameters:
LOAD_SRC, 2'b01, MDE encoding meaning "result comes from data memory"
CNT_W, 32, width of each performance counter

Ports:
clk  input  1  clock
rst  input  1  reset, asynchronous, active-low
A0D  input  5  rs1 of instruction in Decode
A1D  input  5  rs2 of instruction in Decode
A0E  input  5  rs1 of instruction in Execute
A1E  input  5  rs2 of instruction in Execute
A2E  input  5  rd of instruction in Execute
A2M  input  5  rd in Memory
A2W  input  5  rd in Writeback
RWE, RWM, RWW  input  1 each  register-write enable in E/M/W
MDE  input  2  result-source select of E instruction
PCSrcE  input  1  branch taken or jump resolved in E
mdu_reqE  input  1  E instruction is a mul/div op
mdu_done  input  1  MDU result valid; single-cycle pulse
StallF  output  1  hold PC
StallD  output  1  hold F/D register
FlushD  output  1  clear F/D register
StallE  output  1  hold D/E register
FlushE  output  1  clear D/E register (drives clr)
FlushM  output  1  insert bubble into E/M register
FwdAE  output  2  rs1 forward select
FwdBE  output  2  rs2 forward select
mdu_start  output  1  one-cycle MDU start pulse
stall_cnt  output  CNT_W  cycles with StallF=1
flush_cnt  output  CNT_W  cycles with FlushE=1

Behaviour:
- Reset (rst=0, async):
  - FSM goes to IDLE.
  - Counters go to 0.
  - All control outputs, FwdAE/FwdBE and mdu_start are forced to 0 while rst=0.
- Forwarding (combinational, same cycle):
  - FwdAE = 2'b10 if RWM && A2M!=0 && A2M==A0E.
  - Otherwise FwdAE = 2'b01 if RWW && A2W!=0 && A2W==A0E.
  - Otherwise FwdAE = 2'b00.
  - The M stage has priority over W. FwdBE is identical using A1E.
- Load-use (lu) = MDE==LOAD_SRC && RWE && A2E!=0 && (A2E==A0D || A2E==A1D).
  - lu gives StallF=1, StallD=1, FlushE=1 for exactly one cycle per hazard.
- Control hazard: PCSrcE=1 gives FlushD=1 and FlushE=1.
  - Flush beats lu: StallF and StallD stay 0 when PCSrcE=1.
- MDU FSM, states IDLE, BUSY, RELEASE:
  - IDLE and mdu_reqE=1: mdu_start=1 in this cycle; StallF/StallD/StallE=1 and FlushM=1; next state BUSY.
  - BUSY: StallF/StallD/StallE=1 and FlushM=1 every cycle. PCSrcE and lu are ignored.
  - BUSY to RELEASE happens on mdu_done=1. In that cycle the stalls are still asserted.
  - RELEASE lasts one cycle. No stalls from the FSM; E advances with the MDU result. mdu_reqE is ignored, so the same op is never restarted. lu and PCSrcE are evaluated normally. Next state IDLE.
  - mdu_done while IDLE or RELEASE is ignored.
  - Latency: an N-cycle MDU holds E for N+1 cycles. Back-to-back MDU ops restart at the earliest one cycle after RELEASE.
- Priority, highest first:
  1. MDU stall (IDLE start cycle or BUSY). This suppresses flush/lu outputs, except that the FSM's own stall set is asserted.
  2. PCSrcE flush.
  3. lu stall.
- Counters:
  - Increment by 1 each clock with StallF=1 (stall_cnt) or FlushE=1 (flush_cnt).
  - Wrap modulo 2^CNT_W.
- Reset mid-BUSY returns to IDLE immediately. The MDU is expected to be reset by the same rst.

Decomposition:
- Shared package pipeline_pkg:
  - FSM state enum (IDLE=2'd0, BUSY=2'd1, RELEASE=2'd2).
  - Forward select constants FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10.
  - MDE encodings, including LOAD_SRC.
- One sub-module: mdu_seq_fsm. It contains the IDLE/BUSY/RELEASE FSM and generates mdu_start and the MDU stall. Forwarding, lu, priority and counters stay in the top level.

Test Plan:
- Forwarding: A2M=5, RWM=1, A2W=5, RWW=1, A0E=5, A1E=0 -> FwdAE=2'b10, FwdBE=2'b00. Then A2M=0 -> FwdAE=2'b01.
- Load-use: MDE=2'b01, RWE=1, A2E=7, A1D=7 for one cycle -> StallF=StallD=FlushE=1 for one cycle; stall_cnt=1, flush_cnt=1.
- Branch vs load-use: PCSrcE=1 with the same lu condition -> FlushD=FlushE=1, StallF=0, StallD=0.
- MDU: mdu_reqE=1 and mdu_done 4 cycles after start -> mdu_start for 1 cycle, StallE=1 for 5 cycles, RELEASE with no stall, no second mdu_start; stall_cnt=5.
- Reset mid-operation: rst=0 while in BUSY -> outputs and counters 0 immediately. After release with mdu_reqE=0, the FSM stays IDLE and no stalls are asserted.
- Counter wrap: CNT_W=4 with 17 stall cycles -> stall_cnt=1.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared pipeline control types: MDU sequencer states,
// forward selects, result-source encodings, hazard bundle.
package pipeline_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY    = 2'd1,
    RELEASE = 2'd2
  } mdu_state_e;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  typedef enum logic [1:0] {
    MDE_ALU = 2'b00,
    MDE_MEM = 2'b01,
    MDE_PC4 = 2'b10,
    MDE_MDU = 2'b11
  } mde_e;

  typedef struct packed {
    logic stall_f;
    logic stall_d;
    logic flush_d;
    logic stall_e;
    logic flush_e;
    logic flush_m;
  } hz_ctrl_t;

  localparam hz_ctrl_t HZ_NONE = '0;

  // Youngest producer wins; x0 is never forwarded.
  function automatic logic [1:0] fwd_sel(
    input logic [4:0] rs,
    input logic [4:0] rd_m,
    input logic       we_m,
    input logic [4:0] rd_w,
    input logic       we_w
  );
    logic [1:0] sel;
    sel = FWD_RF;
    priority case (1'b1)
      (we_m && rd_m != 5'd0 && rd_m == rs): sel = FWD_MEM;
      (we_w && rd_w != 5'd0 && rd_w == rs): sel = FWD_WB;
      default:                              sel = FWD_RF;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/mdu_seq_fsm.sv
// MDU start/done sequencer: IDLE -> BUSY -> RELEASE -> IDLE.
// Holds the pipeline from the start cycle until done.
module mdu_seq_fsm
  import pipeline_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic req,
  input  logic done,
  output logic start,
  output logic stall
);

  mdu_state_e state_q;
  mdu_state_e state_d;

  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    stall   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req) begin
          start   = 1'b1;
          stall   = 1'b1;
          state_d = BUSY;
        end
      end
      BUSY: begin
        stall = 1'b1;
        if (done) begin
          state_d = RELEASE;
        end
      end
      // E advances with the result; req still shows the old op.
      RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (!rst) begin
      start = 1'b0;
      stall = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/sequencing control for the 5-stage pipeline:
// stalls, flushes, forwarding, MDU handshake, perf counters.
module pipeline_hazard_ctrl
  import pipeline_pkg::*;
#(
  parameter logic [1:0]  LOAD_SRC = MDE_MEM,
  parameter int unsigned CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       A0D,
  input  logic [4:0]       A1D,
  input  logic [4:0]       A0E,
  input  logic [4:0]       A1E,
  input  logic [4:0]       A2E,
  input  logic [4:0]       A2M,
  input  logic [4:0]       A2W,
  input  logic             RWE,
  input  logic             RWM,
  input  logic             RWW,
  input  logic [1:0]       MDE,
  input  logic             PCSrcE,
  input  logic             mdu_reqE,
  input  logic             mdu_done,
  output logic             StallF,
  output logic             StallD,
  output logic             FlushD,
  output logic             StallE,
  output logic             FlushE,
  output logic             FlushM,
  output logic [1:0]       FwdAE,
  output logic [1:0]       FwdBE,
  output logic             mdu_start,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  logic             mdu_stall;
  logic             fsm_start;
  logic             lu;
  hz_ctrl_t         hz;
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q;
  logic [CNT_W-1:0] flush_cnt_d;

  mdu_seq_fsm u_mdu_seq (
    .clk   (clk),
    .rst   (rst),
    .req   (mdu_reqE),
    .done  (mdu_done),
    .start (fsm_start),
    .stall (mdu_stall)
  );

  assign lu = (MDE == LOAD_SRC) && RWE
           && (A2E != 5'd0)
           && ((A2E == A0D) || (A2E == A1D));

  always_comb begin
    hz = HZ_NONE;
    priority case (1'b1)
      !rst: hz = HZ_NONE;
      mdu_stall: begin
        hz.stall_f = 1'b1;
        hz.stall_d = 1'b1;
        hz.stall_e = 1'b1;
        hz.flush_m = 1'b1;
      end
      PCSrcE: begin
        hz.flush_d = 1'b1;
        hz.flush_e = 1'b1;
      end
      lu: begin
        hz.stall_f = 1'b1;
        hz.stall_d = 1'b1;
        hz.flush_e = 1'b1;
      end
      default: hz = HZ_NONE;
    endcase
  end

  always_comb begin
    FwdAE = FWD_RF;
    FwdBE = FWD_RF;
    if (rst) begin
      FwdAE = fwd_sel(A0E, A2M, RWM, A2W, RWW);
      FwdBE = fwd_sel(A1E, A2M, RWM, A2W, RWW);
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q + CNT_W'(hz.stall_f);
    flush_cnt_d = flush_cnt_q + CNT_W'(hz.flush_e);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign StallF    = hz.stall_f;
  assign StallD    = hz.stall_d;
  assign FlushD    = hz.flush_d;
  assign StallE    = hz.stall_e;
  assign FlushE    = hz.flush_e;
  assign FlushM    = hz.flush_m;
  assign mdu_start = fsm_start;
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule
